ssd_scan_ctrl: RTL and testbench

Time-multiplexing scheduler that shares the single 8-bit seven-segment `pattern` bus and the 4-bit active-low `position` select among four BCD digits. It sits between the BCD counter stage(s) and the board SSD pins, and replaces the fixed single-digit `position` drive of the earlier labs. It cycles through the four digits at a parameterised slot length and inserts an anti-ghosting blank at the start of each slot. It also latches the digit values once per frame so the display never tears.

---
 rtl/ssd_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: four-digit seven-segment scan scheduler.
// Time-multiplexes one active-low segment bus across four active-low digit
// selects. Each slot opens with BLANK_CYC guard cycles to suppress ghosting.
// Digit values are snapshotted once per frame, so a frame never mixes old and
// new values.
// Optional feature: define SSD_LZB_EN to blank leading zeros on digits 3..1.

module ssd_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  output logic [3:0]  position,
  output logic [7:0]  pattern,
  output logic        frame_tick
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0] CntLast  = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankCnt = CntW'(BLANK_CYC);

  // Active-low segments {a,b,c,d,e,f,g}; non-BCD codes show nothing.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      slot_q, slot_d;
  logic [15:0]     lat_digits_q, lat_digits_d;
  logic [3:0]      lat_dp_q, lat_dp_d;
  logic [3:0]      position_q, position_d;
  logic [7:0]      pattern_q, pattern_d;
  logic            frame_tick_q, frame_tick_d;

  logic            frame_start;
  logic            in_blank;
  logic [3:0]      cur_digit;
  logic            cur_dp;
  logic [3:0]      lzb;

  // State and output registers; everything resets synchronously.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      slot_q       <= 2'd0;
      lat_digits_q <= 16'h0000;
      lat_dp_q     <= 4'h0;
      position_q   <= 4'hF;
      pattern_q    <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      lat_digits_q <= lat_digits_d;
      lat_dp_q     <= lat_dp_d;
      position_q   <= position_d;
      pattern_q    <= pattern_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Next state: slot counter, slot advance, and per-frame snapshot.
  always_comb begin
    frame_start  = en && (cnt_q == '0) && (slot_q == 2'd0);
    lat_digits_d = frame_start ? digits : lat_digits_q;
    lat_dp_d     = frame_start ? dp_in : lat_dp_q;
    cnt_d        = cnt_q;
    slot_d       = slot_q;
    if (!en) begin
      // Disable restarts the schedule from a clean frame boundary.
      cnt_d  = '0;
      slot_d = 2'd0;
    end else if (cnt_q == CntLast) begin
      cnt_d  = '0;
      slot_d = slot_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output decode; uses the _d snapshot so a frame's first slot sees fresh data.
  always_comb begin
    in_blank = (cnt_q < BlankCnt);
    unique case (slot_q)
      2'd0: cur_digit = lat_digits_d[3:0];
      2'd1: cur_digit = lat_digits_d[7:4];
      2'd2: cur_digit = lat_digits_d[11:8];
      2'd3: cur_digit = lat_digits_d[15:12];
    endcase
    cur_dp = lat_dp_d[slot_q];

`ifdef SSD_LZB_EN
    // A digit is a leading zero when it and every digit above it are zero.
    lzb[3] = (lat_digits_d[15:12] == 4'd0);
    lzb[2] = lzb[3] && (lat_digits_d[11:8] == 4'd0);
    lzb[1] = lzb[2] && (lat_digits_d[7:4] == 4'd0);
    lzb[0] = 1'b0;
`else
    lzb = 4'b0000;
`endif

    position_d   = 4'hF;
    pattern_d    = 8'hFF;
    frame_tick_d = frame_start;
    if (en && !in_blank) begin
      position_d = ~(4'b0001 << slot_q);
      pattern_d  = {(lzb[slot_q] ? 7'b1111111 : seg7(cur_digit)), ~cur_dp};
    end
  end

  assign position   = position_q;
  assign pattern    = pattern_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl with REFRESH_DIV=8, BLANK_CYC=2.
// A frame-position model predicts outputs every cycle; directed literal
// checks pin key points of the schedule. Honours SSD_LZB_EN when defined.

module tb_ssd_scan_ctrl;

  localparam int RD = 8;
  localparam int BC = 2;
`ifdef SSD_LZB_EN
  localparam bit Lzb = 1'b1;
`else
  localparam bit Lzb = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  position;
  logic [7:0]  pattern;
  logic        frame_tick;

  int vectors = 0;
  int miscompares = 0;
  int oc = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(
    .REFRESH_DIV(RD),
    .BLANK_CYC  (BC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .digits    (digits),
    .dp_in     (dp_in),
    .position  (position),
    .pattern   (pattern),
    .frame_tick(frame_tick)
  );

  function automatic logic [6:0] seg_ref(input int v);
    logic [6:0] tab [10];
    tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    return tab[v];
  endfunction

  // Model: k counts enabled cycles since the last restart; the frame position
  // k mod 4*RD alone determines slot, guard interval and snapshot reload.
  logic [3:0]  m_pos;
  logic [7:0]  m_pat;
  logic        m_ft;
  int          m_k;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;

  always @(posedge clk) begin : model
    int ph;
    int s;
    int v;
    logic [15:0] sd;
    logic [3:0]  sp;
    bit          lead;
    if (!rst_n) begin
      m_k <= 0; m_dig <= 16'h0; m_dp <= 4'h0;
      m_pos <= 4'hF; m_pat <= 8'hFF; m_ft <= 1'b0;
    end else if (!en) begin
      m_k <= 0;
      m_pos <= 4'hF; m_pat <= 8'hFF; m_ft <= 1'b0;
    end else begin
      ph = m_k % (4 * RD);
      s  = ph / RD;
      sd = (ph == 0) ? digits : m_dig;
      sp = (ph == 0) ? dp_in : m_dp;
      m_dig <= sd;
      m_dp  <= sp;
      m_k   <= m_k + 1;
      m_ft  <= (ph == 0);
      if ((ph % RD) < BC) begin
        m_pos <= 4'hF;
        m_pat <= 8'hFF;
      end else begin
        v    = int'(sd[s*4 +: 4]);
        lead = Lzb && (s > 0) && ((sd >> (4 * s)) == 16'h0);
        m_pos <= ~(4'b0001 << s);
        m_pat <= {((v < 10) && !lead) ? seg_ref(v) : 7'b1111111, ~sp[s]};
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      vectors++;
      if (position !== m_pos || pattern !== m_pat || frame_tick !== m_ft) begin
        miscompares++;
        $display("FAIL model t=%0t oc=%0d: got pos=%b pat=%h tick=%b, want pos=%b pat=%h tick=%b",
                 $time, oc, position, pattern, frame_tick, m_pos, m_pat, m_ft);
      end
    end
  end

  task automatic lit(input string name, input logic [3:0] pos, input logic [7:0] pat,
                     input logic ft);
    vectors++;
    if (position !== pos || pattern !== pat || frame_tick !== ft) begin
      miscompares++;
      $display("FAIL %s oc=%0d: got pos=%b pat=%h tick=%b, want pos=%b pat=%h tick=%b",
               name, oc, position, pattern, frame_tick, pos, pat, ft);
    end
  endtask

  task automatic step();
    @(negedge clk);
    oc++;
  endtask

  task automatic go(input int target);
    while (oc < target) step();
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    digits = 16'h1234;
    dp_in  = 4'b0001;

    @(negedge clk);
    chk_on = 1'b1;
    lit("reset_c1", 4'hF, 8'hFF, 1'b0);
    @(negedge clk);
    lit("reset_c2", 4'hF, 8'hFF, 1'b0);
    @(negedge clk);
    lit("reset_c3", 4'hF, 8'hFF, 1'b0);

    // Release: output cycle 1 follows the first enabled edge.
    rst_n = 1'b1;
    oc = 0;
    go(1);  lit("first_tick", 4'hF, 8'hFF, 1'b1);
    go(2);  lit("guard_c2",   4'hF, 8'hFF, 1'b0);
    go(3);  lit("d0_first",   4'hE, 8'h98, 1'b0);
    go(8);  lit("d0_last",    4'hE, 8'h98, 1'b0);
    go(9);  lit("s1_guard",   4'hF, 8'hFF, 1'b0);
    go(11); lit("d1",         4'hD, 8'h0D, 1'b0);
    go(19); lit("d2",         4'hB, 8'h25, 1'b0);
    go(27); lit("d3",         4'h7, 8'h9F, 1'b0);
    go(32); lit("frame_end",  4'h7, 8'h9F, 1'b0);
    go(33); lit("tick_32",    4'hF, 8'hFF, 1'b1);

    // Mid-frame change in slot 1 stays hidden until the next frame.
    go(43); digits = 16'h5678;
    go(51); lit("old_d2",     4'hB, 8'h25, 1'b0);
    go(59); lit("old_d1",     4'h7, 8'h9F, 1'b0);
    go(65); lit("tick_64",    4'hF, 8'hFF, 1'b1);
    go(67); lit("new_d0_8",   4'hE, 8'h00, 1'b0);
    go(75); lit("new_d1_7",   4'hD, 8'h1F, 1'b0);
    go(83); lit("new_d2_6",   4'hB, 8'h41, 1'b0);
    go(91); lit("new_d3_5",   4'h7, 8'h49, 1'b0);

    // Enable drop in slot 2 for 5 cycles.
    go(115); en = 1'b0;
    go(116); lit("en_off",    4'hF, 8'hFF, 1'b0);
    go(120); en = 1'b1;
    oc = 0;
    go(1);  lit("reen_tick",  4'hF, 8'hFF, 1'b1);
    go(3);  lit("reen_d0",    4'hE, 8'h00, 1'b0);

    // Reset mid-slot aborts immediately.
    go(13); rst_n = 1'b0;
    step(); lit("mid_reset",  4'hF, 8'hFF, 1'b0);
    rst_n = 1'b1;
    oc = 0;
    go(1);  lit("rst_tick",   4'hF, 8'hFF, 1'b1);

    // Non-BCD digit and zeros above it.
    go(6);  en = 1'b0;
    step();
    digits = 16'h00A0;
    en = 1'b1;
    oc = 0;
    go(3);  lit("a0_d0",      4'hE, 8'h02, 1'b0);
    go(11); lit("code10",     4'hD, 8'hFF, 1'b0);
    go(19); lit("a0_d2",      4'hB, Lzb ? 8'hFF : 8'h03, 1'b0);
    go(27); lit("a0_d3",      4'h7, Lzb ? 8'hFF : 8'h03, 1'b0);

    // All zeros: digit0 is never blanked.
    go(32); digits = 16'h0000;
    go(35); lit("z_d0",       4'hE, 8'h02, 1'b0);
    go(43); lit("z_d1",       4'hD, Lzb ? 8'hFF : 8'h03, 1'b0);
    go(51); lit("z_d2",       4'hB, Lzb ? 8'hFF : 8'h03, 1'b0);
    go(59); lit("z_d3",       4'h7, Lzb ? 8'hFF : 8'h03, 1'b0);
    go(64);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
